// File: rtl/z_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: owns PC/IR, drives z_ALU, the register file and the memory handshake.
// Optional build macro Z_ILLEGAL_TRAP_EN: illegal instructions trap and halt instead of retiring as NOPs.
module z_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_ins,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        instr_done,
  output logic        halted,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] wd_cnt;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_rtype;
  logic        is_branch;
  logic        is_memop;
  logic        is_store;
  logic        is_legal;
  logic [4:0]  dest_reg;
  logic [31:0] branch_target;
  logic        wd_expired;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_memop  = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_store  = (opcode == OP_SW);
  assign is_legal  = is_rtype ? (funct inside {FN_SLL, FN_SRL, FN_ADDU, FN_SUB, FN_NOR})
                              : (opcode inside {OP_BEQ, OP_BNE, OP_ADDIU, OP_ANDI, OP_LW, OP_SW});
  assign dest_reg  = is_rtype ? ir[15:11] : ir[20:16];

  // PC already points past the branch when EXEC runs, so the offset is relative to PC+4.
  assign branch_target = pc + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign wd_expired    = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

  assign rf_ra1    = ir[25:21];
  assign rf_ra2    = ir[20:16];
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_shamt = ir[10:6];
  assign alu_ins   = ir;

`ifdef Z_ILLEGAL_TRAP_EN
  logic trap_q;
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking; blocking
  // assignments would let later statements observe half-updated registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= 32'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      wd_cnt     <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      rf_we      <= 1'b0;
      rf_wa      <= 5'd0;
      rf_wd      <= 32'd0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
`ifdef Z_ILLEGAL_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      // NOTE: one-cycle strobes default low every cycle; only the state that fires them sets them.
      rf_we      <= 1'b0;
      instr_done <= 1'b0;

      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            // First fetch after reset: launch the request from PC.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            wd_cnt   <= 32'd0;
          end else if (mem_ready) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata;
            pc      <= pc + 32'd4;
            state   <= S_DECODE;
          end else if (wd_expired) begin
            mem_req <= 1'b0;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end

        S_DECODE: begin
          a_reg <= rf_rd1;
          b_reg <= rf_rd2;
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
`ifdef Z_ILLEGAL_TRAP_EN
            trap_q <= 1'b1;
            halted <= 1'b1;
            state  <= S_HALT;
`else
            instr_done <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= pc;
            wd_cnt     <= 32'd0;
            state      <= S_FETCH;
`endif
          end
        end

        S_EXEC: begin
          if (is_branch) begin
            // alu_zero already encodes beq/bne polarity.
            if (alu_zero) pc <= branch_target;
            instr_done <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= alu_zero ? branch_target : pc;
            wd_cnt     <= 32'd0;
            state      <= S_FETCH;
          end else if (is_memop) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= alu_out;
            mem_wdata <= b_reg;
            wd_cnt    <= 32'd0;
            state     <= S_MEM;
          end else begin
            rf_we <= (dest_reg != 5'd0);
            rf_wa <= dest_reg;
            rf_wd <= alu_out;
            state <= S_WB;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            if (mem_we) begin
              instr_done <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= pc;
              wd_cnt     <= 32'd0;
              state      <= S_FETCH;
            end else begin
              mem_req <= 1'b0;
              rf_we   <= (ir[20:16] != 5'd0);
              rf_wa   <= ir[20:16];
              rf_wd   <= mem_rdata;
              state   <= S_WB;
            end
          end else if (wd_expired) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end

        S_WB: begin
          instr_done <= 1'b1;
          mem_req    <= 1'b1;
          mem_we     <= 1'b0;
          mem_addr   <= pc;
          wd_cnt     <= 32'd0;
          state      <= S_FETCH;
        end

        S_HALT: begin
          mem_req <= 1'b0;
        end

        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_multicycle_ctrl.sv
// Directed bench for z_multicycle_ctrl: unified memory, register file and ALU stub models.
module tb_z_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa, alu_shamt;
  logic [31:0] rf_rd1, rf_rd2, rf_wd, alu_a, alu_b, alu_ins, alu_out;
  logic        rf_we, alu_zero, instr_done, halted, trap;

  logic [31:0] mem [256];
  logic [31:0] rf  [32];
  logic [31:0] sext;
  int          fetch_waits, data_waits, pending;
  bit          block_ready, fresh, granted;
  int          checks = 0;
  int          errors = 0;

  z_multicycle_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_ins(alu_ins),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .instr_done(instr_done), .halted(halted), .trap(trap)
  );

  initial forever #5 clk = ~clk;

  assign rf_rd1 = (rf_ra1 == 5'd0) ? 32'd0 : rf[rf_ra1];
  assign rf_rd2 = (rf_ra2 == 5'd0) ? 32'd0 : rf[rf_ra2];

  // ALU stub: bne reports zero=1 when operands differ, so zero always means "taken".
  always_comb begin
    alu_out  = 32'd0;
    alu_zero = 1'b0;
    sext     = {{16{alu_ins[15]}}, alu_ins[15:0]};
    case (alu_ins[31:26])
      6'h00: case (alu_ins[5:0])
               6'h21: alu_out = alu_a + alu_b;
               6'h22: alu_out = alu_a - alu_b;
               6'h27: alu_out = ~(alu_a | alu_b);
               6'h00: alu_out = alu_b << alu_shamt;
               6'h02: alu_out = alu_b >> alu_shamt;
               default: alu_out = 32'd0;
             endcase
      6'h09, 6'h23, 6'h2B: alu_out = alu_a + sext;
      6'h0C: alu_out = alu_a & {16'd0, alu_ins[15:0]};
      6'h04: begin alu_out = alu_a - alu_b; alu_zero = (alu_a == alu_b); end
      6'h05: begin alu_out = alu_a - alu_b; alu_zero = (alu_a != alu_b); end
      default: alu_out = 32'd0;
    endcase
  end

  // Memory and register-file write side, updated mid-cycle.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    fresh     = 1'b1;
    granted   = 1'b0;
    pending   = 0;
    forever begin
      @(negedge clk);
      if (rf_we && rf_wa != 5'd0) rf[rf_wa] = rf_wd;
      if (rst || !mem_req || granted) begin
        fresh   = 1'b1;
        granted = 1'b0;
      end
      mem_ready = 1'b0;
      if (!rst && mem_req && !block_ready) begin
        if (fresh) begin
          pending = (mem_addr >= 32'h100) ? data_waits : fetch_waits;
          fresh   = 1'b0;
        end
        if (pending > 0) begin
          pending = pending - 1;
        end else begin
          mem_ready = 1'b1;
          granted   = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    fetch_waits = 0;
    data_waits  = 0;
    block_ready = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    begin_test();
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++;
    if (rf_we !== 1'b0 || instr_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: rf_we=%b instr_done=%b want 0", rf_we, instr_done);
    end
    checks++;
    if (halted !== 1'b0 || trap !== 1'b0) begin
      errors++; $display("FAIL reset_flags: halted=%b trap=%b want 0", halted, trap);
    end
    checks++;
    if (alu_ins !== 32'd0 || mem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_regs: ins=%h addr=%h want 0", alu_ins, mem_addr);
    end
    checks++;
    block_ready = 1'b1;
    release_rst();
    step();
    step();
    if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
      errors++; $display("FAIL reset_stall_fetch: req=%b addr=%h want 1/%h", mem_req, mem_addr, RST_PC);
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_async_drop: got %b want 0", mem_req); end
    checks++;
    block_ready = 1'b0;
    release_rst();
    step();
    if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
      errors++; $display("FAIL reset_refetch: req=%b addr=%h want 1/%h", mem_req, mem_addr, RST_PC);
    end
    checks++;
  endtask

  task automatic test_addu();
    int we_cyc, done_cnt;
    logic [4:0]  wa;
    logic [31:0] wd;
    begin_test();
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    mem[4] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    release_rst();
    we_cyc = 0; done_cnt = 0; wa = 5'd0; wd = 32'd0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (rf_we && we_cyc == 0) begin we_cyc = c; wa = rf_wa; wd = rf_wd; end
      if (instr_done) done_cnt++;
    end
    if (we_cyc !== 4) begin errors++; $display("FAIL addu_we_cycle: got %0d want 4", we_cyc); end
    checks++;
    if (wa !== 5'd3 || wd !== 32'd12) begin
      errors++; $display("FAIL addu_write: wa=%0d wd=%0d want 3/12", wa, wd);
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL addu_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (rf[3] !== 32'd12) begin errors++; $display("FAIL addu_rf: got %0d want 12", rf[3]); end
    checks++;
  endtask

  task automatic run_branch(input string name, input logic [5:0] op, input logic [31:0] r2,
                            input logic [15:0] imm, input logic [31:0] exp_addr);
    begin_test();
    rf[1] = 32'd9;
    rf[2] = r2;
    mem[4] = enc_i(op, 5'd1, 5'd2, imm);
    release_rst();
    for (int c = 1; c <= 4; c++) step();
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      errors++; $display("FAIL %s_next_pc: req=%b addr=%h want 1/%h", name, mem_req, mem_addr, exp_addr);
    end
    checks++;
    if (instr_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, instr_done); end
    checks++;
  endtask

  task automatic test_branch();
    run_branch("beq_taken", 6'h04, 32'd9, 16'd4, 32'h24);
    run_branch("beq_not_taken", 6'h04, 32'd8, 16'd4, 32'h14);
    run_branch("bne_taken", 6'h05, 32'd8, 16'd4, 32'h24);
    run_branch("beq_backward", 6'h04, 32'd9, 16'hFFFE, 32'h0C);
  endtask

  task automatic test_lw_wait();
    int held;
    begin_test();
    rf[1] = 32'h100;
    mem[8'h42] = 32'hDEAD_BEEF;
    mem[4] = enc_i(6'h23, 5'd1, 5'd4, 16'd8);
    data_waits = 2;
    release_rst();
    held = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (mem_req && !mem_we && mem_addr == 32'h108) held++;
      if (c == 7) begin
        if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL lw_wb: we=%b wa=%0d wd=%h want 1/4/deadbeef", rf_we, rf_wa, rf_wd);
        end
        checks++;
      end
    end
    if (held !== 3) begin errors++; $display("FAIL lw_addr_held: got %0d want 3", held); end
    checks++;
    if (rf[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rf: got %h want deadbeef", rf[4]); end
    checks++;
  endtask

  task automatic test_sw();
    begin_test();
    rf[1] = 32'h100;
    rf[2] = 32'h0000_55AA;
    mem[4] = enc_i(6'h2B, 5'd1, 5'd2, 16'd4);
    release_rst();
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 4) begin
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'h55AA) begin
          errors++;
          $display("FAIL sw_bus: req=%b we=%b addr=%h data=%h want 1/1/104/55aa",
                   mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
      end
      if (c == 5) begin
        if (instr_done !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h14) begin
          errors++;
          $display("FAIL sw_retire: done=%b we=%b addr=%h want 1/0/14", instr_done, mem_we, mem_addr);
        end
        checks++;
      end
    end
    if (mem[8'h41] !== 32'h55AA) begin errors++; $display("FAIL sw_mem: got %h want 55aa", mem[8'h41]); end
    checks++;
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    begin_test();
    rf[1] = 32'h0000_00FF;
    rf[2] = 32'h0000_0100;
    mem[4] = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h22);
    mem[5] = enc_i(6'h0C, 5'd1, 5'd6, 16'hF0F0);
    mem[6] = enc_i(6'h09, 5'd1, 5'd7, 16'hFFFF);
    mem[7] = enc_r(5'd0, 5'd1, 5'd8, 5'd4, 6'h00);
    release_rst();
    done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (instr_done) done_cnt++;
    end
    if (done_cnt !== 4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", done_cnt); end
    checks++;
    if (rf[5] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_sub: got %h want ffffffff", rf[5]); end
    checks++;
    if (rf[6] !== 32'h0000_00F0) begin errors++; $display("FAIL b2b_andi: got %h want f0", rf[6]); end
    checks++;
    if (rf[7] !== 32'h0000_00FE) begin errors++; $display("FAIL b2b_addiu: got %h want fe", rf[7]); end
    checks++;
    if (rf[8] !== 32'h0000_0FF0) begin errors++; $display("FAIL b2b_sll: got %h want ff0", rf[8]); end
    checks++;
  endtask

  task automatic test_r0_write();
    int we_cnt;
    begin_test();
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    mem[4] = enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h21);
    release_rst();
    we_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (rf_we) we_cnt++;
      if (c == 5) begin
        if (instr_done !== 1'b1) begin errors++; $display("FAIL r0_retire: got %b want 1", instr_done); end
        checks++;
      end
    end
    if (we_cnt !== 0) begin errors++; $display("FAIL r0_suppressed: rf_we seen %0d want 0", we_cnt); end
    checks++;
  endtask

  task automatic test_illegal();
    int wr_cnt;
    begin_test();
    rf[1] = 32'd1;
    mem[4] = 32'hFC00_0000;
    release_rst();
    wr_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (rf_we || (mem_req && mem_we)) wr_cnt++;
      if (c == 3) begin
`ifdef Z_ILLEGAL_TRAP_EN
        if (trap !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0 || instr_done !== 1'b0) begin
          errors++;
          $display("FAIL illegal_trap: trap=%b halted=%b req=%b done=%b want 1/1/0/0",
                   trap, halted, mem_req, instr_done);
        end
`else
        if (instr_done !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h14 || trap !== 1'b0) begin
          errors++;
          $display("FAIL illegal_nop: done=%b req=%b addr=%h trap=%b want 1/1/14/0",
                   instr_done, mem_req, mem_addr, trap);
        end
`endif
        checks++;
      end
    end
    if (wr_cnt !== 0) begin errors++; $display("FAIL illegal_writes: got %0d want 0", wr_cnt); end
    checks++;
  endtask

  task automatic test_timeout();
    begin_test();
    block_ready = 1'b1;
    release_rst();
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 4) begin
        if (mem_req !== 1'b1 || halted !== 1'b0) begin
          errors++; $display("FAIL timeout_early: req=%b halted=%b want 1/0", mem_req, halted);
        end
        checks++;
      end
      if (c == 5 || c == 8) begin
        if (halted !== 1'b1 || mem_req !== 1'b0) begin
          errors++; $display("FAIL timeout_halt_c%0d: halted=%b req=%b want 1/0", c, halted, mem_req);
        end
        checks++;
      end
    end
  endtask

  task automatic test_timeout_race();
    begin_test();
    fetch_waits = 3;
    release_rst();
    for (int c = 1; c <= 5; c++) step();
    if (halted !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_race: halted=%b req=%b want 0/0", halted, mem_req);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_branch();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_r0_write();
    test_illegal();
    test_timeout();
    test_timeout_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
